// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op encodings, op legality check and arbiter state type.
package pa_riscv;

   localparam logic [3:0] ADD = 4'b0000;
   localparam logic [3:0] SUB = 4'b1000;
   localparam logic [3:0] AND = 4'b0111;
   localparam logic [3:0] OR  = 4'b0110;
   localparam logic [3:0] XOR = 4'b0100;

   typedef enum logic {
      ALU_ARB_IDLE = 1'b0,
      ALU_ARB_HOLD = 1'b1
   } alu_arb_state_e;

   function automatic logic isLegalAluOp(input logic [3:0] op);
      case (op)
         ADD, SUB, AND, OR, XOR: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
   parameter int unsigned NUM_REQ = 2
);
   logic [NUM_REQ-1:0]       i_reqValid;
   logic [NUM_REQ-1:0]       o_reqReady;
   logic [NUM_REQ-1:0][31:0] i_reqA;
   logic [NUM_REQ-1:0][31:0] i_reqB;
   logic [NUM_REQ-1:0][3:0]  i_reqOp;
   logic [NUM_REQ-1:0]       o_rspValid;
   logic [NUM_REQ-1:0]       i_rspReady;
   logic [31:0]              o_rspResult;
   logic                     o_rspZero;
   logic                     o_rspIllegal;

   modport master (
      output i_reqValid, i_reqA, i_reqB, i_reqOp, i_rspReady,
      input  o_reqReady, o_rspValid, o_rspResult, o_rspZero, o_rspIllegal
   );

   modport slave (
      input  i_reqValid, i_reqA, i_reqB, i_reqOp, i_rspReady,
      output o_reqReady, o_rspValid, o_rspResult, o_rspZero, o_rspIllegal
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; unknown op codes produce result 0 (zero flag set).
module alu
   import pa_riscv::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [3:0]  i_op,
   output logic [31:0] o_result,
   output logic        o_zeroFlag
);

   always_comb begin
      o_result = '0;
      case (i_op)
         ADD:     o_result = i_a + i_b;
         SUB:     o_result = i_a + ~i_b + 32'd1;
         AND:     o_result = i_a & i_b;
         OR:      o_result = i_a | i_b;
         XOR:     o_result = i_a ^ i_b;
         default: o_result = '0;
      endcase
      o_zeroFlag = (o_result == '0);
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between NUM_REQ requesters, holding one registered response at a time.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grants; fixed lowest-index priority otherwise.
module alu_arbiter
   import pa_riscv::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input logic          i_clk,
   input logic          i_rst_n,
   alu_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   alu_arb_state_e   state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [31:0]      result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;

   logic [IDX_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               any_valid;
   logic               found;
   logic               release_rsp;
   logic               can_accept;
   logic               accept;
   logic [31:0]        alu_result;
   logic               alu_zero;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q, ptr_d;
   int unsigned      idx;

   // Search starts at the pointer and wraps past NUM_REQ-1 back to 0.
   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!found && bus.i_reqValid[IDX_W'(idx)]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(idx);
         end
      end
   end
`else
   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!found && bus.i_reqValid[IDX_W'(k)]) begin
            found     = 1'b1;
            grant_idx = IDX_W'(k);
         end
      end
   end
`endif

   assign any_valid   = |bus.i_reqValid;
   assign grant       = any_valid ? (NUM_REQ'(1) << grant_idx) : '0;
   assign release_rsp = (state_q == ALU_ARB_HOLD) && bus.i_rspReady[owner_q];
   assign can_accept  = i_rst_n && ((state_q == ALU_ARB_IDLE) || release_rsp);
   assign accept      = can_accept && any_valid;

   assign bus.o_reqReady = can_accept ? grant : '0;

   alu u_alu (
      .i_a        (bus.i_reqA[grant_idx]),
      .i_b        (bus.i_reqB[grant_idx]),
      .i_op       (bus.i_reqOp[grant_idx]),
      .o_result   (alu_result),
      .o_zeroFlag (alu_zero)
   );

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      ptr_d     = ptr_q;
`endif
      // A release and a new accept in the same cycle simply replace the held response.
      if (accept) begin
         state_d   = ALU_ARB_HOLD;
         owner_d   = grant_idx;
         result_d  = alu_result;
         zero_d    = alu_zero;
         illegal_d = !isLegalAluOp(bus.i_reqOp[grant_idx]);
`ifdef ALU_ARB_ROUND_ROBIN_EN
         ptr_d     = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
      end else if (release_rsp) begin
         state_d = ALU_ARB_IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ALU_ARB_IDLE;
         owner_q   <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign bus.o_rspValid   = (state_q == ALU_ARB_HOLD) ? (NUM_REQ'(1) << owner_q) : '0;
   assign bus.o_rspResult  = result_q;
   assign bus.o_rspZero    = zero_q;
   assign bus.o_rspIllegal = illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two requesters.
module tb_alu_arbiter;
   import pa_riscv::*;

   logic clk = 1'b0;
   logic rst_n;
   int unsigned chk_cnt = 0;
   int unsigned err_cnt = 0;

   alu_arbiter_if #(.NUM_REQ(2)) bus ();

   alu_arbiter #(.NUM_REQ(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int unsigned r, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op);
      bus.i_reqA[r]  = a;
      bus.i_reqB[r]  = b;
      bus.i_reqOp[r] = op;
   endtask

   task automatic check_rsp(input string tag, input logic [1:0] vld, input logic [31:0] res,
                            input logic zero, input logic ill);
      check_eq({tag, "_valid"}, 32'(bus.o_rspValid), 32'(vld));
      check_eq({tag, "_result"}, bus.o_rspResult, res);
      check_eq({tag, "_zero"}, 32'(bus.o_rspZero), 32'(zero));
      check_eq({tag, "_illegal"}, 32'(bus.o_rspIllegal), 32'(ill));
   endtask

   initial begin
      logic [1:0] exp_g;

      rst_n          = 1'b0;
      bus.i_reqValid = 2'b11;
      bus.i_rspReady = 2'b00;
      set_req(0, '0, '0, ADD);
      set_req(1, '0, '0, ADD);
      tick();
      tick();
      check_eq("rst_reqReady", 32'(bus.o_reqReady), 32'd0);
      check_rsp("rst", 2'b00, 32'd0, 1'b0, 1'b0);
      bus.i_reqValid = 2'b00;
      rst_n          = 1'b1;
      tick();

      // req0 ADD 5+7
      set_req(0, 32'd5, 32'd7, ADD);
      bus.i_reqValid = 2'b01;
      #1 check_eq("add_reqReady", 32'(bus.o_reqReady), 32'b01);
      tick();
      bus.i_reqValid = 2'b00;
      check_rsp("add", 2'b01, 32'd12, 1'b0, 1'b0);
      bus.i_rspReady = 2'b01;
      tick();
      check_eq("add_drain", 32'(bus.o_rspValid), 32'd0);
      bus.i_rspReady = 2'b00;

      // req1 SUB 3-3 then back-to-back SUB 0-1
      set_req(1, 32'd3, 32'd3, SUB);
      bus.i_reqValid = 2'b10;
      #1 check_eq("sub0_reqReady", 32'(bus.o_reqReady), 32'b10);
      tick();
      check_rsp("sub0", 2'b10, 32'd0, 1'b1, 1'b0);
      set_req(1, 32'd0, 32'd1, SUB);
      bus.i_rspReady = 2'b10;
      #1 check_eq("sub1_reqReady", 32'(bus.o_reqReady), 32'b10);
      tick();
      bus.i_reqValid = 2'b00;
      check_rsp("sub1", 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      check_eq("sub_drain", 32'(bus.o_rspValid), 32'd0);

      // Both requesters always valid, response always accepted
      set_req(0, 32'd1, 32'd0, ADD);
      set_req(1, 32'd2, 32'd0, ADD);
      bus.i_reqValid = 2'b11;
      bus.i_rspReady = 2'b11;
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_g = 2'b01;
`endif
         #1 check_eq("arb_reqReady", 32'(bus.o_reqReady), 32'(exp_g));
         tick();
         check_eq("arb_rspValid", 32'(bus.o_rspValid), 32'(exp_g));
         check_eq("arb_result", bus.o_rspResult, (exp_g == 2'b01) ? 32'd1 : 32'd2);
      end
      bus.i_reqValid = 2'b00;
      tick();
      check_eq("arb_drain", 32'(bus.o_rspValid), 32'd0);

      // req0 XOR held while its owner stalls; req1 waits
      set_req(0, 32'hF0F0_0000, 32'h0FF0_0000, XOR);
      bus.i_reqValid = 2'b01;
      bus.i_rspReady = 2'b00;
      tick();
      bus.i_reqValid = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1 check_eq("hold_reqReady", 32'(bus.o_reqReady), 32'd0);
         check_rsp("hold", 2'b01, 32'hFF00_0000, 1'b0, 1'b0);
         tick();
      end
      bus.i_rspReady = 2'b01;
      #1 check_eq("hold_handoff", 32'(bus.o_reqReady), 32'b10);
      tick();
      bus.i_reqValid = 2'b00;
      check_rsp("handoff", 2'b10, 32'd2, 1'b0, 1'b0);
      bus.i_rspReady = 2'b10;
      tick();
      bus.i_rspReady = 2'b00;

      // Illegal op then a legal OR
      set_req(0, 32'd1, 32'd2, 4'b1111);
      bus.i_reqValid = 2'b01;
      tick();
      check_rsp("illegal", 2'b01, 32'd0, 1'b1, 1'b1);
      set_req(0, 32'd1, 32'd2, OR);
      bus.i_rspReady = 2'b01;
      tick();
      bus.i_reqValid = 2'b00;
      check_rsp("or", 2'b01, 32'd3, 1'b0, 1'b0);
      tick();

      // Reset while holding req0 (pointer would otherwise favour req1)
      bus.i_rspReady = 2'b00;
      set_req(0, 32'd1, 32'd0, ADD);
      bus.i_reqValid = 2'b01;
      tick();
      bus.i_reqValid = 2'b00;
      check_rsp("prerst", 2'b01, 32'd1, 1'b0, 1'b0);
      rst_n          = 1'b0;
      bus.i_reqValid = 2'b11;
      #1 check_eq("inrst_reqReady", 32'(bus.o_reqReady), 32'd0);
      tick();
      check_rsp("postrst", 2'b00, 32'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1 check_eq("postrst_grant", 32'(bus.o_reqReady), 32'b01);
      tick();
      bus.i_reqValid = 2'b00;
      check_eq("postrst_owner", 32'(bus.o_rspValid), 32'b01);
      check_eq("postrst_result", bus.o_rspResult, 32'd1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
